inv_key_schedule_seq: RTL
=========================

// Module: inv_key_schedule_seq
// PURPOSE
//  Sequential AES-128 inverse key schedule for the decryption datapath.
//  Takes the final round key (round NR) and walks the schedule backwards, one round key per handshake.
//  Emits round keys NR, NR-1, ..., 0 in the order the inverse cipher consumes them.
//  Runs on the fly, so no (NR+1)x128-bit schedule storage is needed.
// PARAMETERS
//  NK  4   key length in 32-bit words; only 4 (AES-128) is supported
//  NR  10  number of rounds; the first key emitted is tagged NR
// PORTS
//  clk       in   1      system clock, all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      one-cycle request; samples key_in
//  key_in    in   128    round-NR key, bit order [0:127], word0 = [0:31]
//  rk_ready  in   1      consumer accepts rk_out this cycle
//  rk_valid  out  1      rk_out / rk_round valid
//  rk_out    out  128    current round key, bit order [0:127]
//  rk_round  out  4      round index of rk_out (NR down to 0)
//  busy      out  1      high from accepted start until the final handshake
//  done      out  1      one-cycle pulse in the cycle after round-0 key is accepted
// BEHAVIOUR
//  States: IDLE, EMIT.
//  Reset: state=IDLE; rk_valid=0, rk_out=0, rk_round=0, busy=0, done=0.
//   Reset takes effect mid-sequence with no further outputs.
//  IDLE:
//   start=1 at edge t: rk_out<=key_in, rk_round<=NR, rk_valid<=1, busy<=1, state<=EMIT.
//   First key is visible at t+1 (1-cycle latency).
//  EMIT: rk_valid=1. rk_out and rk_round hold stable while rk_ready=0.
//  Handshake = rk_valid & rk_ready at an edge.
//   rk_round>0: rk_out<=prev(rk_out, rk_round), rk_round<=rk_round-1.
//    One new key per cycle under continuous ready.
//   rk_round==0: rk_valid<=0, busy<=0, done<=1, state<=IDLE.
//  done is high for exactly one cycle, then cleared.
//  start while busy: ignored, no restart, no effect on the current key.
//  start in the same cycle as done: accepted (state is IDLE).
//  prev() for round key w0..w3 at round i (all XOR, 32-bit words):
//   p3 = w3^w2
//   p2 = w2^w1
//   p1 = w1^w0
//   p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(i)
//  RotWord: {b1,b2,b3,b0}.
//  SubWord: FIPS-197 forward S-box on each byte, as a combinational constant table inside this block.
//  Rcon(i) = {rc_i, 24'h0}; rc_1..rc_10 = 01,02,04,08,10,20,40,80,1b,36.
//  prev() is combinational from registered state; one S-box level per cycle.
//  No width growth; rk_round is never decremented below 0.
// TESTING
//  T1 reset, start=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 ->
//     11 consecutive valid cycles; first key = key_in (round 10);
//     round 9 = ac7766f319fadc2128d12941575c006e;
//     round 1 = a0fafe1788542cb123a339392a6c7605;
//     round 0 = 2b7e151628aed2a6abf7158809cf4f3c; then done pulse, busy=0.
//  T2 same key, rk_ready random 30% ->
//     identical 11-key sequence; rk_out/rk_round stable whenever !rk_ready.
//  T3 start pulsed again at round 5 ->
//     ignored; sequence continues unchanged to round 0.
//  T4 rst asserted while rk_round=6 ->
//     next cycle rk_valid=0, busy=0, rk_out=0;
//     fresh start gives correct round-10 key.
//  T5 start asserted in the done cycle with key_in=all zeros ->
//     new run starts; round 10 key = 0, round 9 derived via prev().
//  T6 scoreboard: random 128-bit cipher keys expanded by a forward model, round 10 fed in ->
//     all 11 emitted keys match the model in reverse order.

Source files
------------

// File: rtl/inv_key_schedule_seq_if.sv
// Round-key stream bundle for the inverse AES-128 key schedule.
// The master issues start/key_in and rk_ready; the slave returns the key stream.
interface inv_key_schedule_seq_if;
    logic         start;
    logic [0:127] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [0:127] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_out, rk_round, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_out, rk_round, busy, done
    );
endinterface

// File: rtl/inv_key_schedule_seq.sv
// Sequential AES-128 inverse key schedule: emits round keys NR down to 0.
// Each accepted key is turned into its predecessor by one combinational step.
module inv_key_schedule_seq #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input logic                   clk,
    input logic                   rst,
    inv_key_schedule_seq_if.slave bus
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [31:0] w [NK];
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    logic [0:127] prev_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        unique case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Undo one forward expansion step on the currently presented key.
    always_comb begin
        for (int i = 0; i < NK; i++) begin
            w[i] = bus.rk_out[32*i +: 32];
        end
        p3 = w[3] ^ w[2];
        p2 = w[2] ^ w[1];
        p1 = w[1] ^ w[0];
        rot = {p3[23:0], p3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]),
               sbox(rot[15:8]), sbox(rot[7:0])};
        p0 = w[0] ^ sub ^ {rcon(bus.rk_round), 24'h0};
        prev_key = {p0, p1, p2, p3};
    end

    // Control FSM with registered stream outputs; a key holds until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.rk_valid <= 1'b0;
            bus.rk_out   <= '0;
            bus.rk_round <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.rk_out   <= bus.key_in;
                        bus.rk_round <= 4'(NR);
                        bus.rk_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.rk_valid && bus.rk_ready) begin
                        if (bus.rk_round != 4'd0) begin
                            bus.rk_out   <= prev_key;
                            bus.rk_round <= bus.rk_round - 4'd1;
                        end else begin
                            bus.rk_valid <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
